// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key tracker: prefix/control bytes,
// the scan-code parser states and the default arrow-key code table.
package ps2_pkg;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  localparam logic [7:0] CTL_ERR0  = 8'h00;
  localparam logic [7:0] CTL_BAT   = 8'hAA;
  localparam logic [7:0] CTL_ECHO  = 8'hEE;
  localparam logic [7:0] CTL_ACK   = 8'hFA;
  localparam logic [7:0] CTL_RSND  = 8'hFE;
  localparam logic [7:0] CTL_ERR1  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } parser_state_t;

  // Index 0 sits in the low bits: left, up, right, down.
  localparam int unsigned   ARROW_NUM_KEYS  = 4;
  localparam logic [35:0]   ARROW_KEY_CODES = {9'h172, 9'h174, 9'h175, 9'h16B};

  function automatic logic is_ctrl_byte(input logic [7:0] b);
    return (b == CTL_ERR0) || (b == CTL_BAT)  || (b == CTL_ECHO) ||
           (b == CTL_ACK)  || (b == CTL_RSND) || (b == CTL_ERR1);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous event queue with push/full/pop/empty handshake; a push into a
// full queue is taken only when a pop retires the head in the same cycle.
module ps2_event_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // Storage is not reset, so the head is masked to zero while empty.
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ps2_key_tracker.sv
// Turns a PS/2 scan-code byte stream into per-key held levels and a queue of
// make/break/repeat events for a configurable set of tracked keys.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int unsigned              NUM_KEYS       = ARROW_NUM_KEYS,
  parameter logic [9*NUM_KEYS-1:0]    KEY_CODES      = ARROW_KEY_CODES,
  parameter int unsigned              FIFO_DEPTH     = 8,
  parameter int unsigned              TIMEOUT_CYCLES = 50000,
  parameter bit                       REPEAT_EN      = 1'b0,
  localparam int unsigned             IDXW           = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                key,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [NUM_KEYS-1:0] held,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [IDXW+1:0]     ev_data,
  output logic                ovf,
  output logic                seq_err
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  parser_state_t       state_q, state_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [NUM_KEYS-1:0] held_q, held_d;
  logic                ovf_q, ovf_d;
  logic                seq_err_q, seq_err_d;

  logic                code_done, code_brk;
  logic [8:0]          code;
  logic                hit;
  logic [IDXW-1:0]     hit_idx;
  logic                push;
  logic [IDXW+1:0]     push_data;
  logic                fifo_full, fifo_empty, pop;

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    seq_err_d = 1'b0;
    code_done = 1'b0;
    code_brk  = 1'b0;
    code      = '0;
    if (rx_valid) begin
      tmo_d = '0;
      if (is_ctrl_byte(rx_data)) begin
        state_d   = IDLE;
        seq_err_d = (state_q != IDLE);
      end else begin
        unique case (state_q)
          IDLE: begin
            if (rx_data == PFX_EXT)      state_d = EXT;
            else if (rx_data == PFX_BRK) state_d = BRK;
            else begin
              code_done = 1'b1;
              code      = {1'b0, rx_data};
            end
          end
          EXT: begin
            if (rx_data == PFX_BRK)      state_d = EXT_BRK;
            else if (rx_data == PFX_EXT) state_d = EXT;
            else begin
              code_done = 1'b1;
              code      = {1'b1, rx_data};
              state_d   = IDLE;
            end
          end
          BRK: begin
            if (rx_data == PFX_EXT) state_d = EXT_BRK;
            else begin
              code_done = 1'b1;
              code_brk  = 1'b1;
              code      = {1'b0, rx_data};
              state_d   = IDLE;
            end
          end
          EXT_BRK: begin
            code_done = 1'b1;
            code_brk  = 1'b1;
            code      = {1'b1, rx_data};
            state_d   = IDLE;
          end
        endcase
      end
    end else if (state_q != IDLE) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d   = IDLE;
        tmo_d     = '0;
        seq_err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // First match wins so duplicated table entries resolve to the lowest index.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (!hit && (code == KEY_CODES[9*i +: 9])) begin
        hit     = 1'b1;
        hit_idx = IDXW'(i);
      end
    end
  end

  always_comb begin
    held_d    = held_q;
    push      = 1'b0;
    push_data = '0;
    if (code_done && hit) begin
      if (code_brk) begin
        if (held_q[hit_idx]) begin
          held_d[hit_idx] = 1'b0;
          push            = 1'b1;
          push_data       = {1'b1, 1'b0, hit_idx};
        end
      end else if (!held_q[hit_idx]) begin
        held_d[hit_idx] = 1'b1;
        push            = 1'b1;
        push_data       = {1'b0, 1'b0, hit_idx};
      end else if (REPEAT_EN) begin
        push      = 1'b1;
        push_data = {1'b0, 1'b1, hit_idx};
      end
    end
  end

  assign pop   = !fifo_empty && ev_ready;
  assign ovf_d = ovf_q || (push && fifo_full && !pop);

  always_ff @(posedge clk) begin
    if (!key) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      held_q    <= '0;
      ovf_q     <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      held_q    <= held_d;
      ovf_q     <= ovf_d;
      seq_err_q <= seq_err_d;
    end
  end

  ps2_event_fifo #(
    .WIDTH (IDXW + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (key),
    .push      (push),
    .push_data (push_data),
    .full      (fifo_full),
    .pop       (pop),
    .pop_data  (ev_data),
    .empty     (fifo_empty)
  );

  assign held     = held_q;
  assign ev_valid = !fifo_empty;
  assign ovf      = ovf_q;
  assign seq_err  = seq_err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench: one tracker with default parameters and one with typematic
// repeats enabled, sharing the byte stream and consumer handshake.
module tb_ps2_key_tracker;

  logic       clk = 1'b0;
  logic       key = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       ev_ready = 1'b0;

  logic [3:0] held0, held1;
  logic       ev_valid0, ev_valid1;
  logic [3:0] ev_data0, ev_data1;
  logic       ovf0, ovf1, seq0, seq1;

  int total = 0;
  int bad   = 0;
  int pops0 = 0;
  int seq_cnt = 0;
  logic [3:0] q0[$];
  logic [3:0] q1[$];

  always #5 clk = ~clk;

  ps2_key_tracker u_dut (
    .clk(clk), .key(key), .rx_data(rx_data), .rx_valid(rx_valid),
    .held(held0), .ev_valid(ev_valid0), .ev_ready(ev_ready),
    .ev_data(ev_data0), .ovf(ovf0), .seq_err(seq0)
  );

  ps2_key_tracker #(.REPEAT_EN(1'b1)) u_rep (
    .clk(clk), .key(key), .rx_data(rx_data), .rx_valid(rx_valid),
    .held(held1), .ev_valid(ev_valid1), .ev_ready(ev_ready),
    .ev_data(ev_data1), .ovf(ovf1), .seq_err(seq1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (key && ev_valid0 && ev_ready) begin
      pops0++;
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL ev_dut: got unexpected event %0h expected none", ev_data0);
      end else check("ev_dut", ev_data0, q0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (key && ev_valid1 && ev_ready) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL ev_rep: got unexpected event %0h expected none", ev_data1);
      end else check("ev_rep", ev_data1, q1.pop_front());
    end
  end

  always @(negedge clk) if (seq0) seq_cnt++;

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic exp_both(input logic [3:0] d);
    q0.push_back(d);
    q1.push_back(d);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] kc [4];
    int s0, lat, p0, ev;
    bit found, drained;
    kc = '{8'h6B, 8'h75, 8'h74, 8'h72};

    repeat (3) @(posedge clk);
    #1;
    check("rst_held", held0, 0);
    check("rst_ev_valid", ev_valid0, 0);
    check("rst_ev_data", ev_data0, 0);
    check("rst_ovf", ovf0, 0);
    check("rst_seq_err", seq0, 0);
    key = 1'b1;
    ev_ready = 1'b1;

    exp_both(4'b0000);
    send(8'hE0); send(8'h6B);
    check("make_left_held", held0, 4'b0001);
    exp_both(4'b1000);
    send(8'hE0); send(8'hF0); send(8'h6B);
    check("break_left_held", held0, 4'b0000);

    exp_both(4'b0001);
    q1.push_back(4'b0101);
    q1.push_back(4'b0101);
    repeat (3) begin send(8'hE0); send(8'h75); end
    check("repeat_held_dut", held0, 4'b0010);
    check("repeat_held_rep", held1, 4'b0010);
    exp_both(4'b1001);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("break_up_held", held1, 4'b0000);

    send(8'hE0); send(8'h12);
    send(8'hE0); send(8'hF0); send(8'h74);
    send(8'h6B);
    check("nomatch_held", held0, 4'b0000);

    s0 = seq_cnt;
    send(8'hAA); settle();
    check("ctrl_idle_no_err", seq_cnt, s0);
    send(8'hE0); send(8'hAA); settle();
    check("ctrl_abort_err", seq_cnt, s0 + 1);
    send(8'h6B);
    check("ctrl_abort_idle", held0, 4'b0000);

    send(8'hE0);
    found = 1'b0; lat = 0;
    for (int n = 1; n <= 50010 && !found; n++) begin
      @(negedge clk);
      if (seq0) begin found = 1'b1; lat = n; end
    end
    check("timeout_seen", found, 1);
    check("timeout_latency", lat, 50001);
    @(negedge clk);
    check("timeout_pulse_width", seq0, 0);
    send(8'h6B);
    check("timeout_idle", held0, 4'b0000);

    settle();
    check("pre_ovf", ovf0, 0);
    ev_ready = 1'b0;
    ev = 0;
    for (int p = 0; p < 5; p++) begin
      if (ev < 8) exp_both({2'b00, 2'(p % 4)});
      send(8'hE0); send(kc[p % 4]);
      check("fill_make_held", held0, 32'(1 << (p % 4)));
      ev++;
      if (ev < 8) exp_both({2'b10, 2'(p % 4)});
      send(8'hE0); send(8'hF0); send(kc[p % 4]);
      check("fill_break_held", held0, 0);
      ev++;
      if (ev == 8) check("ovf_at_full", ovf0, 0);
    end
    check("ovf_dut", ovf0, 1);
    check("ovf_rep", ovf1, 1);
    check("full_valid", ev_valid0, 1);

    exp_both(4'b0000);
    send(8'hE0);
    @(posedge clk); #1;
    rx_data = 8'h6B; rx_valid = 1'b1; ev_ready = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; ev_ready = 1'b0;
    check("full_push_held", held0, 4'b0001);
    check("full_push_ovf", ovf0, 1);
    p0 = pops0;
    ev_ready = 1'b1;
    drained = 1'b0;
    for (int n = 0; n < 50 && !drained; n++) begin
      @(posedge clk); #1;
      if (!ev_valid0) drained = 1'b1;
    end
    check("drain_done", drained, 1);
    check("drain_count", pops0 - p0, 8);
    exp_both(4'b1000);
    send(8'hE0); send(8'hF0); send(8'h6B);
    settle();

    send(8'hE0); send(8'hF0);
    s0 = seq_cnt;
    @(posedge clk); #1; key = 1'b0;
    @(posedge clk); #1; key = 1'b1;
    send(8'h74); settle();
    check("rst_seq_held", held0, 4'b0000);
    check("rst_seq_no_event", ev_valid0, 0);
    check("rst_seq_no_err", seq_cnt, s0);
    check("rst_seq_ovf_clr", ovf0, 0);

    send(8'hE0);
    @(posedge clk); #1; key = 1'b0; rx_data = 8'hE0; rx_valid = 1'b1;
    @(posedge clk); #1; key = 1'b1; rx_valid = 1'b0;
    send(8'h74);
    check("rst_ignores_rx", held0, 4'b0000);

    exp_both(4'b0010);
    send(8'hE0); send(8'h74);
    check("post_rst_make", held0, 4'b0100);
    exp_both(4'b1010);
    send(8'hE0); send(8'hF0); send(8'h74);
    check("post_rst_break", held0, 4'b0000);

    settle();
    check("q_dut_empty", q0.size(), 0);
    check("q_rep_empty", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 The block SHALL have parameter NUM_KEYS, default 4, giving the number of tracked keys (1..16).
REQ-002 The block SHALL have parameter KEY_CODES, default {9'h172,9'h174,9'h175,9'h16B} (down, right, up, left), holding one 9-bit code per key; bit8 = E0-extended, index i at bits [9i+8:9i].
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8 (power of two, 2..64), giving the event queue depth.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 50000, giving the idle cycles after which a partial sequence is abandoned.
REQ-005 The block SHALL have parameter REPEAT_EN, default 0; when set to 1, typematic repeats are queued as events.
REQ-006 The block SHALL provide port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL provide port key, input, 1 bit: reset, synchronous and active-low.
REQ-008 The block SHALL provide port rx_data, input, 8 bits: the scan-code byte from the PS/2 controller.
REQ-009 The block SHALL provide port rx_valid, input, 1 bit: a one-cycle strobe qualifying rx_data.
REQ-010 The block SHALL provide port held, output, NUM_KEYS bits: level high while key i is down.
REQ-011 The block SHALL provide port ev_valid, output, 1 bit: the event queue is non-empty.
REQ-012 The block SHALL provide port ev_ready, input, 1 bit: the consumer accepts the head event.
REQ-013 The block SHALL provide port ev_data, output, IDXW+2 bits, as {is_break, is_repeat, index}, where IDXW = max(1, clog2(NUM_KEYS)).
REQ-014 The block SHALL provide port ovf, output, 1 bit: sticky flag set when an event is dropped.
REQ-015 The block SHALL provide port seq_err, output, 1 bit: a one-cycle pulse on timeout or on an aborted prefix.

Function
REQ-016 The parser SHALL have exactly four states: IDLE, EXT (after E0), BRK (after F0) and EXT_BRK (after E0 F0).
REQ-017 In IDLE, byte E0 SHALL move the parser to EXT, F0 SHALL move it to BRK, and any other byte SHALL be a make of {0,byte} with the parser remaining in IDLE.
REQ-018 In EXT, F0 SHALL move the parser to EXT_BRK, E0 SHALL keep it in EXT, and any other byte SHALL be a make of {1,byte} followed by a return to IDLE.
REQ-019 In BRK, E0 SHALL move the parser to EXT_BRK, and any other byte SHALL be a break of {0,byte} followed by a return to IDLE.
REQ-020 In EXT_BRK, any byte SHALL be a break of {1,byte} followed by a return to IDLE.
REQ-021 In any state, control bytes 00, AA, EE, FA, FE and FF SHALL force IDLE with no event; seq_err SHALL pulse if the parser was not in IDLE.
REQ-022 A completed code matching no KEY_CODES entry SHALL change nothing; if several entries match, only the lowest index SHALL be used.
REQ-023 On a make for key i with held[i]=0, held[i] SHALL be set to 1 and {0,0,i} pushed.
REQ-024 On a make for key i with held[i]=1, held SHALL be unchanged; {0,1,i} SHALL be pushed only when REPEAT_EN=1.
REQ-025 On a break for key i with held[i]=1, held[i] SHALL be cleared to 0 and {1,0,i} pushed; a break with held[i]=0 SHALL produce no event.
REQ-026 Latency: held and the FIFO write SHALL update on the edge that samples the completing rx_valid, so ev_valid rises the next cycle when the queue was empty.
REQ-027 The timeout counter SHALL clear on every rx_valid and count while the parser is not IDLE; reaching TIMEOUT_CYCLES-1 SHALL force IDLE and pulse seq_err.
REQ-028 The FIFO SHALL pop when ev_valid and ev_ready are both high; ev_data SHALL be the head entry and stable while ev_valid=1 and ev_ready=0.
REQ-029 When the FIFO is full, a push SHALL be accepted only if a pop occurs in the same cycle; otherwise the event SHALL be dropped and ovf set, while held still updates.
REQ-030 When the FIFO is empty, ev_valid SHALL be 0 and ev_ready SHALL be ignored; pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-031 While key=0 at a clock edge, the block SHALL set: parser IDLE, timeout counter 0, held all 0, FIFO empty, ev_valid=0, ev_data=0, ovf=0, seq_err=0.
REQ-032 rx_valid SHALL be ignored while key=0, and a sequence interrupted by reset SHALL NOT resume after key returns to 1.

Structure
REQ-033 Package ps2_pkg SHALL hold the prefix and control byte constants, the parser state enum, and the default arrow KEY_CODES.
REQ-034 The queue SHALL be implemented as the sub-module ps2_event_fifo, parameterised by width and depth, with push/full/pop/empty ports.

Verification
REQ-035 The bench SHALL drive E0 6B -> expect held=4'b0001, then ev_data={0,0,0}; then E0 F0 6B -> expect held=0 and event {1,0,0}.
REQ-036 The bench SHALL drive E0 75 three times with REPEAT_EN=0 -> expect one event only; with REPEAT_EN=1 -> expect events {0,0,1},{0,1,1},{0,1,1}.
REQ-037 The bench SHALL drive E0, then idle for 50000 cycles -> expect seq_err pulse, parser IDLE; a following 6B (non-extended) SHALL NOT set held.
REQ-038 The bench SHALL hold ev_ready=0 and make/break the 4 keys alternately for 10 events -> expect 8 queued, ovf=1, held correct, and draining order FIFO-correct.
REQ-039 The bench SHALL, with the FIFO full and ev_ready=1, complete a new make -> expect the push accepted, ovf unchanged, and occupancy still 8.
REQ-040 The bench SHALL drive E0 F0, then key=0 for one cycle, then 74 -> expect held=0, no event, seq_err=0, and the parser in IDLE.
